mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits as a responder on the core's data-memory bus, beside the data RAM. It decodes core writes and reads in its own address window. Written bytes are queued in a small FIFO and serialized as 8N1 frames on `tx`. Read timing matches the data RAM's one-cycle registered read port, so the SoC can mux `r_data` with the RAM output without extra alignment logic.

## Interface
- `CLK_DIV`, default 434: clk cycles per UART bit; legal range 2..65535.
- `ADDR_BASE`, default 32'h0000_1000: window base; bits [3:0] ignored.
- `FIFO_DEPTH`, default 4: byte entries; power of two, 2..16.
- `clk`  in  1  clock; the core's clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  bus enable; qualifies writes.
- `w_en`  in  1  write strobe.
- `w_addr`  in  32  byte write address.
- `w_data`  in  32  write data; only [7:0] and the CTRL bits are used.
- `r_en`  in  1  read strobe.
- `r_addr`  in  32  byte read address.
- `r_data`  out  32  registered read data.
- `tx`  out  1  serial output; idles high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Window hit: `addr[31:4] == ADDR_BASE[31:4]`. Register select is `addr[3:2]`:
  - 0 TXDATA (write-only; reads return 0).
  - 1 STATUS (read-only).
  - 2 CTRL.
  - 3 reserved: reads return 0, writes are ignored.
- Write accepted when `en && w_en && hit`.
  - TXDATA write pushes `w_data[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and the sticky `ovf` flag is set.
- CTRL fields:
  - bit0 `tx_en`, reset value 1. When 0, the FIFO is not popped; a frame already in progress completes.
  - bit1 write-1-to-clear `ovf`; reads as 0.
- STATUS fields:
  - [0] full, [1] empty, [2] frame active, [6:3] count (0..FIFO_DEPTH), [7] ovf, [31:8] 0.
- Read behaviour:
  - When `r_en && hit`, `r_data` loads the selected register at the clock edge.
  - When `r_en && !hit`, `r_data` loads 0.
  - When `r_en` is low, `r_data` holds its value.
- Transmitter FSM:
  - IDLE: if FIFO non-empty and `tx_en`, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit index counts 0..7, then STOP.
  - STOP: `tx`=1 for CLK_DIV cycles, then IDLE.
- Baud counter: reloads to 0 on every state entry and counts 0..CLK_DIV-1; the bit ends at CLK_DIV-1. Width is 16 bits.
- `busy` = (state != IDLE) || !empty. `tx` is driven from a register, so it is glitch-free.
- Simultaneous FIFO push and pop in one cycle:
  - Both succeed and count is unchanged.
  - If the FIFO is full, the push is accepted because of the same-cycle pop; `ovf` is not set.
- Simultaneous STATUS read and TXDATA write: STATUS returns the pre-write state.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is held in a separate counter, so full and empty are unambiguous.

## Timing
- Reset values: `tx`=1, `busy`=0, `r_data`=0, state IDLE, FIFO empty, `ovf`=0, `tx_en`=1, baud counter 0.
- Reset asserted mid-frame: the next edge forces all reset values; the FIFO contents are discarded and `tx` returns high immediately.
- Read latency is 1 cycle: address presented before edge N, data valid after edge N.
- Write at edge N into an empty FIFO while idle:
  - Count becomes 1 after N.
  - Pop at edge N+1; `tx` falls after N+1.
  - Frame length is exactly 10·CLK_DIV cycles.
- Back-to-back frames: STOP→IDLE takes 1 edge and the pop takes the next edge. The start bit of frame k+1 begins 10·CLK_DIV+1 cycles after the start of frame k.
- Clearing `tx_en` while idle with data queued: no pop occurs; data is retained and sent once `tx_en` is set again.

## Test plan
- Reset, CLK_DIV=4: after reset, `tx`=1, `busy`=0, `r_data`=0, STATUS read returns 0x00000002.
- Write 0xA5 to TXDATA: `tx` falls one cycle later, then the sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; `busy` drops after the stop bit.
- Write 5 bytes with `tx_en`=0 and FIFO_DEPTH=4:
  - STATUS reads 0x000000A1 (full, count 4, ovf).
  - Write CTRL=0x3: ovf clears, the 4 queued bytes go out with a 41-cycle start-to-start spacing, and the 5th byte is never sent.
- FIFO full and the transmitter pops in the same cycle as a TXDATA write: the write is accepted, ovf stays 0, and all bytes are sent in order.
- Read at a non-window address (0x2000) and a reserved offset (0xC): `r_data`=0 one cycle later. With `r_en` low, `r_data` holds the last STATUS value.
- Assert `rst_n`=0 during DATA bit 3: `tx`=1 and the FIFO is empty after the edge. No further frames are sent after release.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by the UART transmitter.
// The core drives the strobes, addresses and write data.
// The responder returns the registered read data.
interface mmio_uart_tx_if;
  logic        en;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        r_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  modport master (
    output en,
    output w_en,
    output w_addr,
    output w_data,
    output r_en,
    output r_addr,
    input  r_data
  );

  modport slave (
    input  en,
    input  w_en,
    input  w_addr,
    input  w_data,
    input  r_en,
    input  r_addr,
    output r_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Written bytes go into a small FIFO and are then serialized on tx.
// The read port has the same one-cycle registered timing as the data RAM.
module mmio_uart_tx #(
  parameter int          CLK_DIV    = 434,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Address decode and write qualification
  logic w_hit;
  logic r_hit;
  logic wr_acc;
  logic push_req;
  logic push;
  logic pop;
  logic ctrl_wr;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // Control and status
  logic ovf;
  logic tx_en;
  logic [31:0] status_word;
  logic [31:0] ctrl_word;

  // Transmitter datapath
  state_t      state;
  state_t      state_next;
  logic [15:0] baud;
  logic [15:0] baud_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_next;
  logic        baud_done;

  // Byte-lane bits and high data bits that the register map does not use
  logic unused_bits;
  assign unused_bits = ^{bus.w_data[31:8], bus.w_addr[1:0], bus.r_addr[1:0]};

  assign w_hit    = (bus.w_addr[31:4] == ADDR_BASE[31:4]);
  assign r_hit    = (bus.r_addr[31:4] == ADDR_BASE[31:4]);
  assign wr_acc   = bus.en && bus.w_en && w_hit;
  assign push_req = wr_acc && (bus.w_addr[3:2] == REG_TXDATA);
  assign ctrl_wr  = wr_acc && (bus.w_addr[3:2] == REG_CTRL);

  // A full FIFO still takes the byte when the transmitter pops in the same cycle.
  assign push = push_req && (!full || pop);

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign busy  = (state != IDLE) || !empty;

  // The STATUS count field is 4 bits wide, so a depth of 16 reads back as 0 when full.
  assign status_word = {24'd0, ovf, 4'(count), (state != IDLE), empty, full};
  assign ctrl_word   = {31'd0, tx_en};

  assign baud_done = (baud == BAUD_LAST);

  // FIFO storage has no reset: the pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.w_data[7:0];
    end
  end

  // FIFO pointers wrap naturally; a separate count keeps full and empty distinct.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // CTRL register and sticky overflow flag; ovf is set only for a byte that is really lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_en <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        tx_en <= bus.w_data[0];
        if (bus.w_data[1]) begin
          ovf <= 1'b0;
        end
      end
      if (push_req && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Registered read port; it samples pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.r_data <= 32'd0;
    end else if (bus.r_en) begin
      if (!r_hit) begin
        bus.r_data <= 32'd0;
      end else begin
        case (bus.r_addr[3:2])
          REG_STATUS: bus.r_data <= status_word;
          REG_CTRL:   bus.r_data <= ctrl_word;
          default:    bus.r_data <= 32'd0;
        endcase
      end
    end
  end

  // Transmitter state, baud timer, bit index, shifter and line register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  // Next-state logic; tx_next is the line level for the cycle after the edge.
  always_comb begin
    state_next   = state;
    baud_next    = baud + 16'd1;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    tx_next      = tx;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        baud_next = 16'd0;
        tx_next   = 1'b1;
        if (!empty && tx_en) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          state_next   = DATA;
          baud_next    = 16'd0;
          bit_idx_next = 3'd0;
          tx_next      = shift[0];
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_next = 16'd0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
          end
        end
      end

      STOP: begin
        if (baud_done) begin
          state_next = IDLE;
          baud_next  = 16'd0;
          tx_next    = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        baud_next  = 16'd0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLK_DIV=4 and FIFO_DEPTH=4.
// It uses a register-level vector table and hand-written serial-frame sequences.
module tb_mmio_uart_tx;

  localparam int          DIV      = 4;
  localparam logic [31:0] A_TXDATA = 32'h0000_1000;
  localparam logic [31:0] A_STATUS = 32'h0000_1004;
  localparam logic [31:0] A_CTRL   = 32'h0000_1008;
  localparam logic [31:0] A_RSVD   = 32'h0000_100C;

  logic clk;
  logic rst_n;
  logic tx;
  logic busy;

  int checks;
  int errors;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .CLK_DIV    (DIV),
    .ADDR_BASE  (32'h0000_1000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .tx    (tx),
    .busy  (busy)
  );

  // Free-running core clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        r_en;
    logic [31:0] r_addr;
    logic        chk;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic w_en,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input logic r_en, input logic [31:0] ra,
                              input logic chk, input logic [31:0] exp_rdata);
    vec_t v;
    v.en = en; v.w_en = w_en; v.w_addr = wa; v.w_data = wd;
    v.r_en = r_en; v.r_addr = ra; v.chk = chk; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [31:0] d);
    return mk(1'b1, 1'b1, a, d, 1'b0, 32'd0, 1'b0, 32'd0);
  endfunction

  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] e);
    return mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, a, 1'b1, e);
  endfunction

  // Expected line level for frame bit k (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic bus_idle();
    bus_if.en     = 1'b0;
    bus_if.w_en   = 1'b0;
    bus_if.w_addr = 32'd0;
    bus_if.w_data = 32'd0;
    bus_if.r_en   = 1'b0;
    bus_if.r_addr = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector for exactly one edge, then return the bus to idle
  task automatic applyStimulus(input vec_t v);
    bus_if.en     = v.en;
    bus_if.w_en   = v.w_en;
    bus_if.w_addr = v.w_addr;
    bus_if.w_data = v.w_data;
    bus_if.r_en   = v.r_en;
    bus_if.r_addr = v.r_addr;
    step();
    bus_idle();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(wr(a, d));
  endtask

  task automatic do_read(input logic [31:0] a);
    applyStimulus(rd(a, 32'd0));
  endtask

  // Called at sample 0 of the start bit: collects 40 samples of the line and checks the whole frame
  task automatic expect_frame(input logic [7:0] b, input string name);
    logic [39:0] act;
    logic [39:0] exp_w;
    for (int i = 0; i < 10 * DIV; i++) begin
      exp_w[i] = frame_bit(b, i / DIV);
      act[i]   = tx;
      step();
    end
    checkOutput(name, {24'd0, act}, {24'd0, exp_w});
  endtask

  // The line must stay high and busy low for n cycles
  task automatic watch_quiet(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      step();
    end
    checkOutput(name, 64'(bad), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_idle();

    // ---------------- Reset ----------------
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_tx", 64'(tx), 64'd1);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_rdata", 64'(bus_if.r_data), 64'd0);
    do_read(A_STATUS);
    checkOutput("reset_status", 64'(bus_if.r_data), 64'h2);

    // ---------------- Single 0xA5 frame ----------------
    do_write(A_TXDATA, 32'hA5);
    checkOutput("a5_tx_before_pop", 64'(tx), 64'd1);
    checkOutput("a5_busy_queued", 64'(busy), 64'd1);
    step();
    expect_frame(8'hA5, "a5_frame");
    checkOutput("a5_tx_after", 64'(tx), 64'd1);
    checkOutput("a5_busy_after", 64'(busy), 64'd0);

    // ---------------- Register-level vector table ----------------
    vecs.push_back(wr(A_CTRL, 32'h0));
    vecs.push_back(rd(A_CTRL, 32'h0));
    vecs.push_back(rd(A_STATUS, 32'h02));
    vecs.push_back(wr(A_TXDATA, 32'h11));
    vecs.push_back(rd(A_STATUS, 32'h08));
    vecs.push_back(wr(A_TXDATA, 32'h22));
    vecs.push_back(mk(1'b1, 1'b1, A_TXDATA, 32'h33, 1'b1, A_STATUS, 1'b1, 32'h10));
    vecs.push_back(rd(A_STATUS, 32'h18));
    vecs.push_back(wr(A_TXDATA, 32'h44));
    vecs.push_back(rd(A_STATUS, 32'h21));
    vecs.push_back(wr(A_TXDATA, 32'h55));
    vecs.push_back(rd(A_STATUS, 32'hA1));
    vecs.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, A_STATUS, 1'b1, 32'hA1));
    vecs.push_back(rd(A_TXDATA, 32'h0));
    vecs.push_back(rd(A_STATUS, 32'hA1));
    vecs.push_back(rd(A_RSVD, 32'h0));
    vecs.push_back(wr(A_RSVD, 32'hFF));
    vecs.push_back(rd(A_STATUS, 32'hA1));
    vecs.push_back(rd(32'h0000_2000, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, A_CTRL, 32'h3, 1'b0, 32'd0, 1'b0, 32'd0));
    vecs.push_back(wr(32'h0000_2008, 32'h3));
    vecs.push_back(rd(A_CTRL, 32'h0));
    vecs.push_back(rd(A_STATUS, 32'hA1));
    vecs.push_back(rd(32'h0000_1014, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d_rdata", i), 64'(bus_if.r_data), 64'(vecs[i].exp_rdata));
      end
    end

    // ---------------- Enable, clear ovf, drain 4 queued bytes ----------------
    do_write(A_CTRL, 32'h3);
    checkOutput("drain_tx_before_pop", 64'(tx), 64'd1);
    do_read(A_STATUS);
    checkOutput("drain_status_ovf_cleared", 64'(bus_if.r_data), 64'h21);
    expect_frame(8'h11, "drain_frame0");
    checkOutput("drain_gap0", 64'(tx), 64'd1);
    step();
    expect_frame(8'h22, "drain_frame1");
    checkOutput("drain_gap1", 64'(tx), 64'd1);
    step();
    expect_frame(8'h33, "drain_frame2");
    checkOutput("drain_gap2", 64'(tx), 64'd1);
    step();
    expect_frame(8'h44, "drain_frame3");
    watch_quiet(60, "drain_no_fifth_byte");
    do_read(A_STATUS);
    checkOutput("drain_status_end", 64'(bus_if.r_data), 64'h02);

    // ---------------- Push into full FIFO in the same cycle as a pop ----------------
    do_write(A_CTRL, 32'h0);
    do_write(A_TXDATA, 32'h01);
    do_write(A_TXDATA, 32'h02);
    do_write(A_TXDATA, 32'h03);
    do_write(A_TXDATA, 32'h04);
    do_write(A_CTRL, 32'h1);
    do_write(A_TXDATA, 32'h05);
    expect_frame(8'h01, "pp_frame0");
    step();
    expect_frame(8'h02, "pp_frame1");
    step();
    expect_frame(8'h03, "pp_frame2");
    step();
    expect_frame(8'h04, "pp_frame3");
    step();
    expect_frame(8'h05, "pp_frame4");
    watch_quiet(20, "pp_quiet");
    do_read(A_STATUS);
    checkOutput("pp_status_no_ovf", 64'(bus_if.r_data), 64'h02);

    // ---------------- Reset during DATA bit 3 ----------------
    do_write(A_TXDATA, 32'h35);
    do_write(A_TXDATA, 32'h5A);
    repeat (DIV * 4 + 1) step();
    checkOutput("rst_mid_tx_bit3", 64'(tx), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    checkOutput("rst_mid_tx_high", 64'(tx), 64'd1);
    checkOutput("rst_mid_busy_low", 64'(busy), 64'd0);
    checkOutput("rst_mid_rdata", 64'(bus_if.r_data), 64'd0);
    rst_n = 1'b1;
    watch_quiet(80, "rst_no_more_frames");
    do_read(A_STATUS);
    checkOutput("rst_status_empty", 64'(bus_if.r_data), 64'h02);
    do_read(A_CTRL);
    checkOutput("rst_ctrl_txen", 64'(bus_if.r_data), 64'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary line
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
